msx_bus_target: RTL and testbench

Transaction front-end downstream of the MSX bus sampler. It consumes the filtered, clock-aligned cartridge bus signals. It turns each qualifying memory or I/O read/write into one valid/ack request toward an internal device, and drives the return path: read data, the bus-direction request and the CPU wait request. It is the single point where raw bus strobes become request-level events for mappers, sound chips and I/O registers.

---
 rtl/msx_bus_pkg.sv | 32 +++
 rtl/msx_strobe_edge.sv | 35 +++
 rtl/msx_bus_target.sv | 129 ++++++++++++
 tb/tb_msx_bus_target.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX cartridge bus target front-end.
package msx_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } bus_target_state_t;

    // Bit 1 selects I/O space, bit 0 selects write.
    typedef enum logic [1:0] {
        MEM_RD = 2'b00,
        MEM_WR = 2'b01,
        IO_RD  = 2'b10,
        IO_WR  = 2'b11
    } req_kind_t;

    localparam logic [7:0] DOUT_IDLE = 8'hFF;

    function automatic req_kind_t make_kind(input logic io, input logic wr);
        return req_kind_t'({io, wr});
    endfunction

    function automatic logic kind_is_io(input req_kind_t k);
        return k inside {IO_RD, IO_WR};
    endfunction

    function automatic logic kind_is_wr(input req_kind_t k);
        return k inside {MEM_WR, IO_WR};
    endfunction

endpackage

// File: rtl/msx_strobe_edge.sv
// Registers the sampled RD_n/WR_n strobes and flags their falling edges.
module msx_strobe_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rd_n,
    input  logic i_wr_n,
    output logic o_rd_fall,
    output logic o_wr_fall
);

    logic r_prev_rd_n;
    logic r_prev_wr_n;
    logic r_blk_rd;
    logic r_blk_wr;

    // A strobe already low at the last reset edge is masked until it goes
    // high, so it cannot masquerade as a fresh edge once reset releases.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev_rd_n <= 1'b1;
            r_prev_wr_n <= 1'b1;
            r_blk_rd    <= ~i_rd_n;
            r_blk_wr    <= ~i_wr_n;
        end else begin
            r_prev_rd_n <= i_rd_n;
            r_prev_wr_n <= i_wr_n;
            r_blk_rd    <= r_blk_rd & ~i_rd_n;
            r_blk_wr    <= r_blk_wr & ~i_wr_n;
        end
    end

    assign o_rd_fall = r_prev_rd_n & ~i_rd_n & ~r_blk_rd;
    assign o_wr_fall = r_prev_wr_n & ~i_wr_n & ~r_blk_wr;

endmodule

// File: rtl/msx_bus_target.sv
// Turns qualified MSX bus strobes into valid/ack device requests and drives
// the return path (read data, bus direction, CPU wait).
module msx_bus_target
    import msx_bus_pkg::*;
#(
    parameter logic [7:0]  IO_MASK  = 8'hFF,
    parameter logic [7:0]  IO_MATCH = 8'h00,
    parameter int unsigned TIMEOUT  = 64,
    parameter bit          WAIT_EN  = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] BUS_ADDR,
    input  logic [7:0]  BUS_DIN,
    input  logic        BUS_SLTSL_n,
    input  logic        BUS_IORQ_n,
    input  logic        BUS_M1_n,
    input  logic        BUS_RFSH_n,
    input  logic        BUS_RD_n,
    input  logic        BUS_WR_n,
    output logic        REQ_VALID,
    output logic        REQ_IO,
    output logic        REQ_WR,
    output logic [15:0] REQ_ADDR,
    output logic [7:0]  REQ_WDATA,
    input  logic        ACK,
    input  logic [7:0]  RDATA,
    output logic [7:0]  BUS_DOUT,
    output logic        BUS_BUSDIR,
    output logic        BUS_WAIT,
    output logic        ERR
);

    localparam int unsigned    CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    bus_target_state_t r_state;
    bus_target_state_t w_state_nxt;
    req_kind_t         r_kind;
    logic [15:0]       r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_dout;
    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic w_rd_fall;
    logic w_wr_fall;
    logic w_mem_hit;
    logic w_io_hit;
    logic w_start;
    logic w_ack;
    logic w_timeout;

    msx_strobe_edge u_strobe_edge (
        .i_clk     (CLK),
        .i_reset   (RESET),
        .i_rd_n    (BUS_RD_n),
        .i_wr_n    (BUS_WR_n),
        .o_rd_fall (w_rd_fall),
        .o_wr_fall (w_wr_fall)
    );

    assign w_mem_hit = ~BUS_SLTSL_n & BUS_RFSH_n;
    assign w_io_hit  = ~BUS_IORQ_n & BUS_M1_n
                     & ((BUS_ADDR[7:0] & IO_MASK) == IO_MATCH);
    assign w_start   = (r_state == ST_IDLE) & (w_rd_fall | w_wr_fall)
                     & (w_mem_hit | w_io_hit);
    assign w_ack     = (r_state == ST_REQ) & ACK;
    assign w_timeout = (r_state == ST_REQ) & ~ACK & (r_cnt == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_REQ;
            ST_REQ:  if (w_ack || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE: if (BUS_RD_n && BUS_WR_n) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory wins when both decodes hit; a simultaneous RD/WR fall is a write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_kind  <= MEM_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_dout  <= DOUT_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_start) begin
                r_kind  <= make_kind(~w_mem_hit, w_wr_fall);
                r_addr  <= BUS_ADDR;
                r_wdata <= BUS_DIN;
                r_cnt   <= '0;
            end else if (r_state == ST_REQ) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ack && !kind_is_wr(r_kind)) begin
                r_dout <= RDATA;
            end else if (w_timeout && !kind_is_wr(r_kind)) begin
                r_dout <= DOUT_IDLE;
            end
        end
    end

    always_comb begin
        REQ_VALID  = (r_state == ST_REQ);
        BUS_WAIT   = WAIT_EN & (r_state == ST_REQ);
        BUS_BUSDIR = (r_state == ST_DONE) & ~kind_is_wr(r_kind) & ~BUS_RD_n;
    end

    assign REQ_IO    = kind_is_io(r_kind);
    assign REQ_WR    = kind_is_wr(r_kind);
    assign REQ_ADDR  = r_addr;
    assign REQ_WDATA = r_wdata;
    assign BUS_DOUT  = r_dout;
    assign ERR       = r_err;

endmodule

// File: tb/tb_msx_bus_target.sv
// Scoreboard bench for msx_bus_target: directed cases then random bus cycles.
module tb_msx_bus_target;

    localparam int unsigned TMO   = 8;
    localparam logic [7:0]  MASK  = 8'hFE;
    localparam logic [7:0]  MATCH = 8'hA0;

    logic        CLK         = 1'b0;
    logic        RESET       = 1'b1;
    logic [15:0] BUS_ADDR    = '0;
    logic [7:0]  BUS_DIN     = '0;
    logic        BUS_SLTSL_n = 1'b1;
    logic        BUS_IORQ_n  = 1'b1;
    logic        BUS_M1_n    = 1'b1;
    logic        BUS_RFSH_n  = 1'b1;
    logic        BUS_RD_n    = 1'b1;
    logic        BUS_WR_n    = 1'b1;
    logic        ACK         = 1'b0;
    logic [7:0]  RDATA       = '0;
    logic        REQ_VALID, REQ_IO, REQ_WR, BUS_BUSDIR, BUS_WAIT, ERR;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA, BUS_DOUT;

    msx_bus_target #(
        .IO_MASK  (MASK),
        .IO_MATCH (MATCH),
        .TIMEOUT  (TMO),
        .WAIT_EN  (1'b1)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_DIN     (BUS_DIN),
        .BUS_SLTSL_n (BUS_SLTSL_n),
        .BUS_IORQ_n  (BUS_IORQ_n),
        .BUS_M1_n    (BUS_M1_n),
        .BUS_RFSH_n  (BUS_RFSH_n),
        .BUS_RD_n    (BUS_RD_n),
        .BUS_WR_n    (BUS_WR_n),
        .REQ_VALID   (REQ_VALID),
        .REQ_IO      (REQ_IO),
        .REQ_WR      (REQ_WR),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .ACK         (ACK),
        .RDATA       (RDATA),
        .BUS_DOUT    (BUS_DOUT),
        .BUS_BUSDIR  (BUS_BUSDIR),
        .BUS_WAIT    (BUS_WAIT),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_exp_t;

    typedef struct {
        int unsigned len;
        logic        err;
        logic [7:0]  dout;
    } cmp_exp_t;

    req_exp_t    req_q[$];
    cmp_exp_t    cmp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  model_dout = 8'hFF;
    bit          abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {accepted, is_io} from the decode rules; memory has priority.
    function automatic logic [1:0] model_decode(input logic [15:0] a, input logic sltsl_n,
                                                input logic iorq_n, input logic m1_n,
                                                input logic rfsh_n);
        if (!sltsl_n && rfsh_n) return 2'b10;
        if (!iorq_n && m1_n && ((a[7:0] & MASK) == MATCH)) return 2'b11;
        return 2'b00;
    endfunction

    // Monitor: pops request expectations on REQ_VALID rise, completion ones on its fall.
    bit          m_prev = 1'b0;
    int unsigned m_len  = 0;
    always @(negedge CLK) begin
        req_exp_t r;
        cmp_exp_t c;
        if (REQ_VALID === 1'b1 && !m_prev) begin
            if (req_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: REQ_VALID rose with no request expected at %0t", $time);
            end else begin
                r = req_q.pop_front();
                chk("req_io", REQ_IO, r.io);
                chk("req_wr", REQ_WR, r.wr);
                chk("req_addr", REQ_ADDR, r.addr);
                chk("req_wdata", REQ_WDATA, r.wdata);
            end
            m_len = 1;
        end else if (REQ_VALID === 1'b1) begin
            m_len++;
        end
        if (REQ_VALID !== 1'b1 && m_prev) begin
            if (abort) begin
                abort = 1'b0;
                if (cmp_q.size() != 0) void'(cmp_q.pop_front());
            end else if (cmp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: request ended with no completion expected at %0t", $time);
            end else begin
                c = cmp_q.pop_front();
                chk("req_len", m_len, c.len);
                chk("err_pulse", ERR, c.err);
                chk("bus_dout", BUS_DOUT, c.dout);
            end
        end else begin
            chk("err_quiet", ERR, 1'b0);
        end
        m_prev = (REQ_VALID === 1'b1);
    end

    task automatic bus_idle();
        BUS_SLTSL_n = 1'b1;
        BUS_IORQ_n  = 1'b1;
        BUS_M1_n    = 1'b1;
        BUS_RFSH_n  = 1'b1;
        BUS_RD_n    = 1'b1;
        BUS_WR_n    = 1'b1;
    endtask

    task automatic txn(input logic [15:0] addr, input logic [7:0] din,
                       input logic sltsl_n, input logic iorq_n, input logic m1_n,
                       input logic rfsh_n, input bit do_rd, input bit do_wr,
                       input int unsigned ack_dly, input logic [7:0] rdata,
                       input bit early_rel, input int unsigned hold);
        logic [1:0]  dec;
        bit          tmo;
        bit          dir_exp;
        int unsigned len;
        req_exp_t    r;
        cmp_exp_t    c;
        dec     = model_decode(addr, sltsl_n, iorq_n, m1_n, rfsh_n);
        tmo     = (ack_dly >= TMO);
        len     = tmo ? TMO : ack_dly + 1;
        dir_exp = !do_wr && !early_rel;
        @(posedge CLK); #1;
        BUS_ADDR    = addr;
        BUS_DIN     = din;
        BUS_SLTSL_n = sltsl_n;
        BUS_IORQ_n  = iorq_n;
        BUS_M1_n    = m1_n;
        BUS_RFSH_n  = rfsh_n;
        if (do_rd) BUS_RD_n = 1'b0;
        if (do_wr) BUS_WR_n = 1'b0;
        if (dec[1]) begin
            r = '{io: dec[0], wr: do_wr, addr: addr, wdata: din};
            req_q.push_back(r);
            if (!do_wr) model_dout = tmo ? 8'hFF : rdata;
            c = '{len: len, err: tmo, dout: model_dout};
            cmp_q.push_back(c);
            for (int unsigned i = 0; i < len; i++) begin
                @(posedge CLK); #1;
                ACK = 1'b0;
                chk("req_valid", REQ_VALID, 1'b1);
                chk("bus_wait", BUS_WAIT, 1'b1);
                if (early_rel && i == 1) begin
                    BUS_RD_n = 1'b1;
                    BUS_WR_n = 1'b1;
                end
                if (!tmo && i == ack_dly) begin
                    ACK   = 1'b1;
                    RDATA = rdata;
                end else begin
                    RDATA = 8'($urandom);
                end
            end
            @(posedge CLK); #1;
            ACK = 1'b0;
            chk("done_valid", REQ_VALID, 1'b0);
            chk("done_wait", BUS_WAIT, 1'b0);
            chk("busdir_done", BUS_BUSDIR, dir_exp);
            for (int unsigned h = 0; h < hold; h++) begin
                @(posedge CLK); #1;
                chk("busdir_hold", BUS_BUSDIR, dir_exp);
                chk("dout_hold", BUS_DOUT, model_dout);
            end
            BUS_RD_n = 1'b1;
            BUS_WR_n = 1'b1;
            #1;
            chk("busdir_release", BUS_BUSDIR, 1'b0);
            @(posedge CLK); #1;
            chk("idle_valid", REQ_VALID, 1'b0);
        end else begin
            repeat (2) begin
                @(posedge CLK); #1;
                chk("no_req", REQ_VALID, 1'b0);
            end
            BUS_RD_n = 1'b1;
            BUS_WR_n = 1'b1;
            @(posedge CLK); #1;
        end
        bus_idle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, REQ_VALID, 1'b0);
        chk({tag, "_busdir"}, BUS_BUSDIR, 1'b0);
        chk({tag, "_wait"}, BUS_WAIT, 1'b0);
        chk({tag, "_err"}, ERR, 1'b0);
        chk({tag, "_io"}, REQ_IO, 1'b0);
        chk({tag, "_wr"}, REQ_WR, 1'b0);
        chk({tag, "_addr"}, REQ_ADDR, 16'h0000);
        chk({tag, "_wdata"}, REQ_WDATA, 8'h00);
        chk({tag, "_dout"}, BUS_DOUT, 8'hFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_reset_values("rst");

        // Memory read, ACK in third request cycle.
        txn(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 8'hA5, 1'b0, 2);
        // I/O write with masked address match.
        txn(16'h00A1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1);
        // Exclusions: interrupt acknowledge, refresh, address mismatch.
        txn(16'h00A0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h11, 1'b0, 0);
        txn(16'h4002, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h22, 1'b0, 0);
        txn(16'h00B0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h33, 1'b0, 0);
        // Read timeout.
        txn(16'h4001, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 30, 8'h55, 1'b0, 1);
        // Write with strobe released early, ACK five cycles after release.
        txn(16'h8000, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6, 8'h00, 1'b1, 0);
        // RD_n and WR_n fall together: write.
        txn(16'h6000, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h99, 1'b0, 1);
        // Memory and I/O both qualify: memory.
        txn(16'h00A0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h42, 1'b0, 1);
        // ACK on the last allowed cycle beats the timeout.
        txn(16'h4003, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, TMO - 1, 8'hC3, 1'b0, 0);

        // Reset mid-request with RD_n held low.
        @(posedge CLK); #1;
        BUS_ADDR    = 16'h5123;
        BUS_DIN     = 8'h6E;
        BUS_SLTSL_n = 1'b0;
        BUS_RD_n    = 1'b0;
        req_q.push_back('{io: 1'b0, wr: 1'b0, addr: 16'h5123, wdata: 8'h6E});
        cmp_q.push_back('{len: 0, err: 1'b0, dout: 8'h00});
        @(posedge CLK); #1;
        chk("pre_reset_valid", REQ_VALID, 1'b1);
        @(posedge CLK); #1;
        abort = 1'b1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_dout = 8'hFF;
        check_reset_values("midrst");
        repeat (3) begin
            @(posedge CLK); #1;
            chk("no_restart", REQ_VALID, 1'b0);
        end
        bus_idle();
        @(posedge CLK); #1;
        txn(16'h5124, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 8'h7B, 1'b0, 1);

        for (int unsigned t = 0; t < 160; t++) begin
            logic [15:0] a;
            int unsigned sel;
            int unsigned rw;
            logic        s, io, m1, rf;
            bit          rd, wr, er;
            a   = 16'($urandom);
            sel = $urandom_range(0, 3);
            s   = 1'b1;
            io  = 1'b1;
            case (sel)
                0: s = 1'b0;
                1: io = 1'b0;
                2: begin s = 1'($urandom); io = 1'($urandom); end
                default: begin s = 1'b0; io = 1'b0; end
            endcase
            if ($urandom_range(0, 3) != 0) a[7:0] = MATCH | 8'($urandom_range(0, 1));
            m1 = ($urandom_range(0, 4) != 0);
            rf = ($urandom_range(0, 4) != 0);
            rw = $urandom_range(0, 4);
            rd = (rw <= 1) || (rw == 4);
            wr = (rw >= 2);
            er = wr && !rd && ($urandom_range(0, 2) == 0);
            txn(a, 8'($urandom), s, io, m1, rf, rd, wr, $urandom_range(0, 11),
                8'($urandom), er, $urandom_range(0, 2));
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("req_q_drained", req_q.size(), 0);
        chk("cmp_q_drained", cmp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
